// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned F3_LEN = 3;

    localparam logic [F3_LEN-1:0] F3_B  = 3'b000;
    localparam logic [F3_LEN-1:0] F3_H  = 3'b001;
    localparam logic [F3_LEN-1:0] F3_W  = 3'b010;
    localparam logic [F3_LEN-1:0] F3_BU = 3'b100;
    localparam logic [F3_LEN-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Request as latched from the execute stage.
    typedef struct packed {
        logic              load;
        logic              store;
        logic [F3_LEN-1:0] funct3;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } lsu_req_t;

    // Access size in bytes; also the number of byte beats when split.
    function automatic logic [2:0] beat_count(input logic [F3_LEN-1:0] funct3);
        case (funct3[1:0])
            2'b01:   beat_count = 3'd2;
            2'b10:   beat_count = 3'd4;
            default: beat_count = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled byte or halfword by funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [F3_LEN-1:0] funct3,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   ext_c
);

    // Extend from bit 7 or bit 15; words pass through.
    always_comb begin
        ext_c = data;
        case (funct3)
            F3_B:    ext_c = {{24{data[7]}}, data[7:0]};
            F3_BU:   ext_c = {24'd0, data[7:0]};
            F3_H:    ext_c = {{16{data[15]}}, data[15:0]};
            F3_HU:   ext_c = {16'd0, data[15:0]};
            default: ext_c = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: checks requests, splits misaligned
// accesses into byte beats and returns one extended result.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W           = 12,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [F3_LEN-1:0] req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              ram_load,
    output logic              ram_store,
    output logic [F3_LEN-1:0] ram_access,
    output logic [XLEN-1:0]   ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic [XLEN-1:0]   ram_rdata
);

    lsu_state_t        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic              err_q, err_d;
    logic [2:0]        beat_q, beat_d;
    logic [2:0]        nbeats_q, nbeats_d;
    logic [XLEN-1:0]   buf_q, buf_d;

    logic              req_ready_d, resp_valid_d, resp_err_d;
    logic [XLEN-1:0]   resp_rdata_d;
    logic              ram_load_d, ram_store_d;
    logic [F3_LEN-1:0] ram_access_d;
    logic [XLEN-1:0]   ram_addr_d, ram_wdata_d;

    logic [2:0]        size_c;
    logic [XLEN:0]     last_c;
    logic              misal_c, req_err_c;
    logic [XLEN-1:0]   ext_c;

    // Request legality: funct3, operation select, range and alignment.
    always_comb begin
        size_c    = beat_count(req_funct3);
        last_c    = {1'b0, req_addr} + 33'(size_c) - 33'd1;
        misal_c   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                    (req_store && req_funct3[2]) ||
                    (req_load == req_store) ||
                    (|last_c[XLEN:ADDR_W]) ||
                    (misal_c && !SPLIT_MISALIGNED);
    end

    lsu_extend u_extend (
        .funct3 (req_d.funct3),
        .data   (buf_d),
        .ext_c  (ext_c)
    );

    // Next state, beat bookkeeping and next registered outputs.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        err_d    = err_q;
        beat_d   = beat_q;
        nbeats_d = nbeats_q;
        buf_d    = buf_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d    = '{load: req_load, store: req_store, funct3: req_funct3,
                                 addr: req_addr, wdata: req_wdata};
                    err_d    = req_err_c;
                    beat_d   = 3'd0;
                    nbeats_d = misal_c ? size_c : 3'd1;
                    buf_d    = '0;
                    state_d  = req_err_c ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (req_q.load) begin
                    state_d = WAIT;
                end else if (beat_q == nbeats_q - 3'd1) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            WAIT: begin
                if (nbeats_q == 3'd1) begin
                    buf_d = ram_rdata;
                end else begin
                    buf_d[{beat_q[1:0], 3'b000} +: 8] = ram_rdata[7:0];
                end
                if (beat_q == nbeats_q - 3'd1) begin
                    state_d = RESP;
                end else begin
                    beat_d  = beat_q + 3'd1;
                    state_d = ISSUE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        resp_err_d   = (state_d == RESP) && err_d;
        resp_rdata_d = '0;
        if ((state_d == RESP) && req_d.load && !err_d) begin
            resp_rdata_d = (nbeats_d == 3'd2) ? ext_c : buf_d;
        end

        ram_load_d   = 1'b0;
        ram_store_d  = 1'b0;
        ram_access_d = '0;
        ram_addr_d   = '0;
        ram_wdata_d  = '0;
        if (state_d == ISSUE) begin
            ram_load_d  = req_d.load;
            ram_store_d = req_d.store;
            ram_addr_d  = req_d.addr + 32'(beat_d);
            if (nbeats_d == 3'd1) begin
                ram_access_d = req_d.funct3;
                ram_wdata_d  = req_d.store ? req_d.wdata : '0;
            end else begin
                ram_access_d = req_d.load ? F3_BU : F3_B;
                ram_wdata_d  = req_d.store ? {24'd0, req_d.wdata[{beat_d[1:0], 3'b000} +: 8]} : '0;
            end
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            req_q      <= '0;
            err_q      <= 1'b0;
            beat_q     <= '0;
            nbeats_q   <= '0;
            buf_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            ram_load   <= 1'b0;
            ram_store  <= 1'b0;
            ram_access <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            err_q      <= err_d;
            beat_q     <= beat_d;
            nbeats_q   <= nbeats_d;
            buf_q      <= buf_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            ram_load   <= ram_load_d;
            ram_store  <= ram_store_d;
            ram_access <= ram_access_d;
            ram_addr   <= ram_addr_d;
            ram_wdata  <= ram_wdata_d;
        end
    end

endmodule
